instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset (bit 0 SHALL be 0).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  16  byte address of requested instruction.
REQ-006 imem_ack  input  1  memory accepts request and returns imem_rdata in the same cycle.
REQ-007 imem_rdata  input  16  instruction word; sampled only when imem_req && imem_ack.
REQ-008 stall  input  1  downstream hold; the current instruction is not consumed.
REQ-009 pc_load  input  1  redirect request.
REQ-010 pc_load_val  input  16  redirect target.
REQ-011 valid  output  1  instr and decoded fields hold a live instruction.
REQ-012 instr  output  16  instruction register.
REQ-013 op  output  3  instr[15:13]; feeds the control unit opcode input.
REQ-014 rs, rt, rd  output  3 each  instr[12:10], instr[9:7], instr[6:4].
REQ-015 funct  output  4  instr[3:0].
REQ-016 imm  output  7  instr[6:0], zero-extended by the consumer.
REQ-017 pc_out  output  16  address from which instr was fetched.

Function
REQ-018 FSM states SHALL be FETCH, VALID, DRAIN; reset state SHALL be FETCH.
REQ-019 FETCH: imem_req=1 and imem_addr=pc; both SHALL hold stable until imem_ack.
REQ-020 FETCH with imem_ack and no pc_load: instr<=imem_rdata, pc_out<=pc, pc<=pc+2, valid<=1, next state VALID.
REQ-021 Fetch latency: valid SHALL rise on the edge that samples imem_ack, i.e. 1 cycle after the request cycle when ack is immediate.
REQ-022 VALID: imem_req=0; instr, decoded fields, and pc_out SHALL hold constant while stall=1.
REQ-023 VALID with stall=0: instruction consumed at that edge; valid<=0, next state FETCH.
REQ-024 Decoded fields SHALL be pure slices of instr; no extra latency.
REQ-025 PC arithmetic SHALL be 16-bit modulo: pc 16'hFFFE + 2 -> 16'h0000.
REQ-026 pc_load SHALL force bit 0 of the target to 0 (pc<=pc_load_val & 16'hFFFE).
REQ-027 pc_load in VALID (any stall): pc<=target, valid<=0, next state FETCH; the held instruction is discarded.
REQ-028 pc_load in FETCH with imem_ack in the same cycle: pc<=target, the returned word is discarded, valid stays 0, next state FETCH.
REQ-029 pc_load in FETCH without imem_ack: pc<=target, next state DRAIN; the outstanding request to the old address SHALL stay asserted unchanged.
REQ-030 DRAIN: imem_req=1 with the old address; on imem_ack the data is discarded and the next state is FETCH at the new pc; valid stays 0.
REQ-031 A further pc_load in DRAIN SHALL overwrite the pending target; the last value wins.
REQ-032 Simultaneous stall=0 and pc_load: pc_load takes priority.
REQ-033 valid SHALL never be 1 for an instruction fetched from a pre-redirect address.

Reset
REQ-034 rst_n low SHALL immediately force pc=RESET_PC, state=FETCH, imem_req=0, valid=0, instr=16'h0000, pc_out=16'h0000.
REQ-035 Reset asserted mid-request SHALL abandon the request; imem_req SHALL be 0 while rst_n=0.
REQ-036 First request SHALL be issued in the first cycle after rst_n deasserts, at address RESET_PC.

Verification
REQ-037 Reset, immediate ack, rdata=16'h2A51, stall=0 -> valid=1 one cycle later; op=3'b001, rs=3'b010, rt=3'b100, rd=3'b101, funct=4'h1, pc_out=0; next imem_addr=0x0002.
REQ-038 Ack delayed 3 cycles -> imem_req and imem_addr=0x0000 stable for 4 cycles; valid rises after the ack edge.
REQ-039 valid=1 with stall held 5 cycles -> instr and pc_out constant; no imem_req; after stall drops, next fetch at pc_out+2.
REQ-040 pc_load=1, pc_load_val=16'h0041 during an un-acked fetch of 0x0010 -> imem_addr stays 0x0010 until ack, returned data discarded, next request at 0x0040, valid never set for 0x0010.
REQ-041 RESET_PC=16'hFFFE, two fetches -> second imem_addr=16'h0000.
REQ-042 rst_n pulsed low while imem_req=1 -> imem_req=0 and valid=0 asynchronously; refetch from RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus: single-cycle request/ack handshake with read data.
// The fetch unit drives the request side (master) and the memory answers (slave).
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one 16-bit word at a time, holds it under stall,
// and handles redirects, including draining a request that was issued before the redirect.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   instr_fetch_unit_if.master         imem,
   input  logic                       stall,
   input  logic                       pc_load,
   input  logic [15:0]                pc_load_val,
   output logic                       valid,
   output logic [15:0]                instr,
   output logic [2:0]                 op,
   output logic [2:0]                 rs,
   output logic [2:0]                 rt,
   output logic [2:0]                 rd,
   output logic [3:0]                 funct,
   output logic [6:0]                 imm,
   output logic [15:0]                pc_out
);

   typedef enum logic [1:0] {FETCH, VALID, DRAIN} state_t;

   state_t      state, next_state;
   logic [15:0] pc;
   logic [15:0] drain_addr;
   logic [15:0] target;
   logic        fetch_done;

   assign target     = pc_load_val & 16'hFFFE;
   assign fetch_done = (state == FETCH) && imem.imem_ack && !pc_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         FETCH: begin
            if (pc_load) begin
               next_state = imem.imem_ack ? FETCH : DRAIN;
            end else if (imem.imem_ack) begin
               next_state = VALID;
            end
         end
         VALID: begin
            if (pc_load || !stall) begin
               next_state = FETCH;
            end
         end
         DRAIN: begin
            if (imem.imem_ack) begin
               next_state = FETCH;
            end
         end
         default: next_state = FETCH;
      endcase
   end

   // DRAIN keeps presenting the pre-redirect address; the request is masked during reset.
   always_comb begin
      imem.imem_req  = rst_n && (state != VALID);
      imem.imem_addr = (state == DRAIN) ? drain_addr : pc;
      valid          = (state == VALID);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         drain_addr <= 16'h0000;
         instr      <= 16'h0000;
         pc_out     <= 16'h0000;
      end else begin
         if (pc_load) begin
            pc <= target;
         end else if (fetch_done) begin
            pc <= pc + 16'd2;
         end
         if ((state == FETCH) && pc_load && !imem.imem_ack) begin
            drain_addr <= pc;
         end
         if (fetch_done) begin
            instr  <= imem.imem_rdata;
            pc_out <= pc;
         end
      end
   end

   assign op    = instr[15:13];
   assign rs    = instr[12:10];
   assign rt    = instr[9:7];
   assign rd    = instr[6:4];
   assign funct = instr[3:0];
   assign imm   = instr[6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        rst2_n;
   logic        stall;
   logic        pc_load;
   logic [15:0] pc_load_val;
   logic        valid, valid2;
   logic [15:0] instr, instr2, pc_out, pc_out2;
   logic [2:0]  op, rs, rt, rd, op2, rs2, rt2, rd2;
   logic [3:0]  funct, funct2;
   logic [6:0]  imm, imm2;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit_if imem ();
   instr_fetch_unit_if imem2 ();

   instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .imem(imem.master), .stall(stall),
      .pc_load(pc_load), .pc_load_val(pc_load_val), .valid(valid), .instr(instr),
      .op(op), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .pc_out(pc_out)
   );

   instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
      .clk(clk), .rst_n(rst2_n), .imem(imem2.master), .stall(1'b0),
      .pc_load(1'b0), .pc_load_val(16'h0000), .valid(valid2), .instr(instr2),
      .op(op2), .rs(rs2), .rt(rt2), .rd(rd2), .funct(funct2), .imm(imm2), .pc_out(pc_out2)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   assign imem2.imem_ack   = 1'b1;
   assign imem2.imem_rdata = mem_word(imem2.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0;
      imem.imem_ack = 1'b0;
      pc_load = 1'b0;
      stall = 1'b0;
      tick();
      check_output("rst_req", imem.imem_req, 1'b0);
      check_output("rst_valid", valid, 1'b0);
      rst_n = 1'b1;
      #1;
   endtask

   // Randomized-phase model: what the consumer should see, not how the FSM gets there.
   logic        exp_valid;
   logic [15:0] exp_instr, exp_pc_out, exp_next, stale_addr, tgt;
   logic        stale;
   logic        r_stall, r_load, r_ack;
   int          delivered;

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0000;
      imem.imem_ack = 1'b0; imem.imem_rdata = 16'h0000;
      tick(); tick();

      check_output("reset_req", imem.imem_req, 1'b0);
      check_output("reset_valid", valid, 1'b0);
      check_output("reset_instr", instr, 16'h0000);
      check_output("reset_pc_out", pc_out, 16'h0000);

      // Immediate ack of 0x2A51 at address 0
      rst_n = 1'b1; imem.imem_ack = 1'b1; imem.imem_rdata = 16'h2A51;
      #1;
      check_output("first_req", imem.imem_req, 1'b1);
      check_output("first_addr", imem.imem_addr, 16'h0000);
      tick();
      imem.imem_ack = 1'b0;
      check_output("dec_valid", valid, 1'b1);
      check_output("dec_instr", instr, 16'h2A51);
      check_output("dec_op", op, 3'b001);
      check_output("dec_rs", rs, 3'b010);
      check_output("dec_rt", rt, 3'b100);
      check_output("dec_rd", rd, 3'b101);
      check_output("dec_funct", funct, 4'h1);
      check_output("dec_imm", imm, 7'h51);
      check_output("dec_pc_out", pc_out, 16'h0000);
      check_output("dec_no_req", imem.imem_req, 1'b0);
      tick();
      check_output("next_addr", imem.imem_addr, 16'h0002);
      check_output("next_req", imem.imem_req, 1'b1);
      check_output("next_valid", valid, 1'b0);

      // Ack delayed three cycles
      do_reset();
      imem.imem_rdata = 16'h1234;
      for (int i = 0; i < 4; i++) begin
         check_output("slow_req", imem.imem_req, 1'b1);
         check_output("slow_addr", imem.imem_addr, 16'h0000);
         check_output("slow_valid", valid, 1'b0);
         imem.imem_ack = (i == 3);
         tick();
      end
      imem.imem_ack = 1'b0;
      check_output("slow_got_valid", valid, 1'b1);
      check_output("slow_instr", instr, 16'h1234);

      // Stall holds the instruction for five cycles
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_output("stall_valid", valid, 1'b1);
         check_output("stall_instr", instr, 16'h1234);
         check_output("stall_pc_out", pc_out, 16'h0000);
         check_output("stall_no_req", imem.imem_req, 1'b0);
      end
      stall = 1'b0;
      tick();
      check_output("post_stall_addr", imem.imem_addr, 16'h0002);
      check_output("post_stall_req", imem.imem_req, 1'b1);

      // Redirect coinciding with ack discards the returned word
      pc_load = 1'b1; pc_load_val = 16'h0011; imem.imem_ack = 1'b1; imem.imem_rdata = 16'hDEAD;
      tick();
      pc_load = 1'b0; imem.imem_ack = 1'b0;
      check_output("load_ack_valid", valid, 1'b0);
      check_output("load_ack_addr", imem.imem_addr, 16'h0010);

      // Redirect during an un-acked fetch, then a second redirect that wins
      pc_load = 1'b1; pc_load_val = 16'h0061;
      tick();
      check_output("drain_addr0", imem.imem_addr, 16'h0010);
      check_output("drain_req0", imem.imem_req, 1'b1);
      pc_load_val = 16'h0041;
      tick();
      pc_load = 1'b0;
      check_output("drain_addr1", imem.imem_addr, 16'h0010);
      tick();
      check_output("drain_addr2", imem.imem_addr, 16'h0010);
      imem.imem_ack = 1'b1; imem.imem_rdata = 16'hBEEF;
      tick();
      check_output("drain_valid", valid, 1'b0);
      check_output("drain_new_addr", imem.imem_addr, 16'h0040);
      imem.imem_rdata = 16'h1111;
      tick();
      imem.imem_ack = 1'b0;
      check_output("redir_valid", valid, 1'b1);
      check_output("redir_instr", instr, 16'h1111);
      check_output("redir_pc_out", pc_out, 16'h0040);

      // Redirect while holding a stalled instruction
      stall = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0101;
      tick();
      stall = 1'b0; pc_load = 1'b0;
      check_output("vload_valid", valid, 1'b0);
      check_output("vload_addr", imem.imem_addr, 16'h0100);

      // Asynchronous reset in the middle of an outstanding request
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_req", imem.imem_req, 1'b0);
      check_output("async_valid", valid, 1'b0);
      check_output("async_pc_out", pc_out, 16'h0000);
      tick();
      check_output("hold_rst_req", imem.imem_req, 1'b0);
      rst_n = 1'b1;
      #1;
      check_output("refetch_addr", imem.imem_addr, 16'h0000);
      check_output("refetch_req", imem.imem_req, 1'b1);

      // PC wraps from 0xFFFE to 0x0000
      rst2_n = 1'b1;
      #1;
      check_output("wrap_first_addr", imem2.imem_addr, 16'hFFFE);
      check_output("wrap_first_req", imem2.imem_req, 1'b1);
      tick();
      check_output("wrap_valid", valid2, 1'b1);
      check_output("wrap_pc_out", pc_out2, 16'hFFFE);
      check_output("wrap_instr", instr2, mem_word(16'hFFFE));
      check_output("wrap_fields", {op2, rs2, rt2, rd2, funct2}, instr2);
      check_output("wrap_imm", imm2, instr2[6:0]);
      tick();
      check_output("wrap_second_addr", imem2.imem_addr, 16'h0000);
      check_output("wrap_second_req", imem2.imem_req, 1'b1);

      // Randomized run
      do_reset();
      exp_valid = 1'b0; exp_instr = 16'h0000; exp_pc_out = 16'h0000;
      exp_next = 16'h0000; stale = 1'b0; stale_addr = 16'h0000; delivered = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         check_output("rnd_valid", valid, exp_valid);
         check_output("rnd_req", imem.imem_req, !exp_valid);
         if (exp_valid) begin
            check_output("rnd_instr", instr, exp_instr);
            check_output("rnd_pc_out", pc_out, exp_pc_out);
         end else begin
            check_output("rnd_addr", imem.imem_addr, stale ? stale_addr : exp_next);
         end
         r_stall = ($urandom_range(0, 99) < 35);
         r_load  = ($urandom_range(0, 99) < 10);
         r_ack   = ($urandom_range(0, 99) < 55);
         stall = r_stall;
         pc_load = r_load;
         pc_load_val = 16'($urandom);
         imem.imem_ack = r_ack;
         imem.imem_rdata = mem_word(imem.imem_addr);
         tgt = pc_load_val & 16'hFFFE;
         if (exp_valid) begin
            if (r_load) begin
               exp_valid = 1'b0; exp_next = tgt;
            end else if (!r_stall) begin
               exp_valid = 1'b0; exp_next = exp_pc_out + 16'd2;
            end
         end else if (r_ack) begin
            if (r_load) begin
               exp_next = tgt; stale = 1'b0;
            end else if (stale) begin
               stale = 1'b0;
            end else begin
               exp_valid = 1'b1; exp_instr = mem_word(exp_next); exp_pc_out = exp_next;
               delivered++;
            end
         end else if (r_load) begin
            if (!stale) begin
               stale = 1'b1; stale_addr = exp_next;
            end
            exp_next = tgt;
         end
         tick();
      end
      check_output("rnd_liveness", delivered > 100, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
